// File: rtl/exotiny_console_tx_if.sv
// rtl/exotiny_console_tx_if.sv - Wishbone register port bundle for the console transmitter
//
// Purpose: groups the single-register-window Wishbone signals of exotiny_console_tx.
// Signals:
//   wb_stb   strobe, held by the initiator until wb_ack
//   wb_we    1 = write, 0 = read
//   wb_adr   register select: 0 = TXDATA, 1 = STATUS
//   wb_wdat  write data, only [7:0] used
//   wb_rdat  read data, valid while wb_ack = 1
//   wb_ack   single-cycle acknowledge
interface exotiny_console_tx_if;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_adr;
  logic [31:0] wb_wdat;
  logic [31:0] wb_rdat;
  logic        wb_ack;

  modport master (output wb_stb, wb_we, wb_adr, wb_wdat, input wb_rdat, wb_ack);
  modport slave  (input wb_stb, wb_we, wb_adr, wb_wdat, output wb_rdat, wb_ack);
endinterface

// File: rtl/exotiny_console_tx.sv
// rtl/exotiny_console_tx.sv - console byte FIFO, 8N1 UART transmitter and end-of-test marker detector
//
// Purpose: accepts byte stores on a Wishbone responder, queues them in a FIFO and
// serialises them as 8N1 UART. Watches the accepted byte stream for "DONE"/"ERR".
// Ports:
//   clk_i   system clock
//   rst_in  asynchronous reset, active low
//   wb      Wishbone responder (slave modport of exotiny_console_tx_if)
//   tx_o    UART serial out, idle high
//   done_o  sticky, last four accepted bytes were "DONE"
//   err_o   sticky, last three accepted bytes were "ERR"
module exotiny_console_tx #(
  parameter int DEPTH  = 16,
  parameter int CLKDIV = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_in,
  exotiny_console_tx_if.slave        wb,
  output logic                       tx_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(CLKDIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKDIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic [31:0]       marker_q, marker_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        mem_q [DEPTH];

  logic              full, empty, busy, accept, push, pop, bit_end;
  logic [31:0]       status;
  logic              unused_wdat;

  assign unused_wdat = ^wb.wb_wdat[31:8];

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (cnt_q == '0);
  // A TXDATA write while full is simply not accepted yet; the initiator keeps strobing.
  assign accept  = wb.wb_stb & ~ack_q & (~wb.wb_we | wb.wb_adr | ~full);
  assign push    = accept & wb.wb_we & ~wb.wb_adr;
  assign status  = {16'h0, 8'(level_q), 3'b000, err_q, done_q, busy, empty, full};

  // State register
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      marker_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      marker_q <= marker_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage needs no reset: level_q alone says which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wb.wb_wdat[7:0];
  end

  // Next-state logic: UART sequencer, FIFO bookkeeping, bus response, markers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = CNT_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = CNT_RELOAD;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next START so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            cnt_d   = CNT_RELOAD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    if (push && !pop) level_d = level_q + LVL_W'(1);
    if (pop && !push) level_d = level_q - LVL_W'(1);

    ack_d  = accept;
    rdat_d = (accept && !wb.wb_we && wb.wb_adr) ? status : 32'h0;

    marker_d = push ? {marker_q[23:0], wb.wb_wdat[7:0]} : marker_q;
    // Compared one cycle after the shift, so the flags trail the last ack by one cycle.
    done_d   = done_q | (marker_q == 32'h444F_4E45);
    err_d    = err_q  | (marker_q[23:0] == 24'h45_5252);
  end

  // Output logic
  always_comb begin
    unique case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
    wb.wb_ack  = ack_q;
    wb.wb_rdat = rdat_q;
    done_o     = done_q;
    err_o      = err_q;
  end

endmodule
